// File: rtl/dataflow_pkg.sv
// Shared types and helpers for the dataflow actors.
//   acc_state_t    : two-state control of an accumulating actor
//   acc_out_width  : output token width needed to sum `batch` tokens of
//                    `width` bits without overflow
package dataflow_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        PUSH = 1'b1
    } acc_state_t;

    function automatic int acc_out_width(input int width, input int batch);
        return width + $clog2(batch);
    endfunction

endpackage

// File: rtl/actor_accumulate.sv
// actor_accumulate
//   Pops BATCH tokens from an upstream FIFO, sums them (unsigned) and pushes
//   the sum as one token into a downstream FIFO. Stalls on input-empty and on
//   output-full without losing or duplicating tokens.
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous reset, active-low
//   in_empty   : upstream FIFO empty flag
//   in_dout    : upstream FIFO head token (valid while in_empty=0)
//   in_read    : pop strobe to upstream FIFO
//   out_full   : downstream FIFO full flag
//   out_din    : token to push (held stable until pushed)
//   out_write  : push strobe to downstream FIFO
//   batch_cnt  : number of completed output tokens, wraps at 2^16
module actor_accumulate
    import dataflow_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int BATCH     = 4,
    localparam int OUT_WIDTH = acc_out_width(WIDTH, BATCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_empty,
    input  logic [WIDTH-1:0]     in_dout,
    output logic                 in_read,
    input  logic                 out_full,
    output logic [OUT_WIDTH-1:0] out_din,
    output logic                 out_write,
    output logic [15:0]          batch_cnt
);

    localparam int IDX_W = (BATCH > 1) ? $clog2(BATCH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BATCH - 1);

    acc_state_t           state_q, state_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [OUT_WIDTH-1:0] out_din_q, out_din_d;
    logic [15:0]          batch_cnt_q, batch_cnt_d;
    logic [OUT_WIDTH-1:0] acc_sum;

    // Strobes are combinational from registered state and forced low in reset;
    // ACC only reads and PUSH only writes, so they can never coincide.
    assign in_read   = rst & (state_q == ACC)  & ~in_empty;
    assign out_write = rst & (state_q == PUSH) & ~out_full;

    assign acc_sum = acc_q + OUT_WIDTH'(in_dout);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_din_d   = out_din_q;
        batch_cnt_d = batch_cnt_q;
        unique case (state_q)
            ACC: begin
                if (in_read) begin
                    if (idx_q == IDX_LAST) begin
                        // Last token of the batch goes straight into the
                        // output register; the accumulator restarts clean.
                        out_din_d = acc_sum;
                        acc_d     = '0;
                        idx_d     = '0;
                        state_d   = PUSH;
                    end else begin
                        acc_d = acc_sum;
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PUSH: begin
                if (out_write) begin
                    batch_cnt_d = batch_cnt_q + 16'd1;
                    state_d     = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ACC;
            acc_q       <= '0;
            idx_q       <= '0;
            out_din_q   <= '0;
            batch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_din_q   <= out_din_d;
            batch_cnt_q <= batch_cnt_d;
        end
    end

    assign out_din   = out_din_q;
    assign batch_cnt = batch_cnt_q;

endmodule
